// File: rtl/video_mode_ctrl_if.sv
// Bundles the video_mode_ctrl request handshake, sync-generator position feed,
// and timing/status outputs; slave = controller side, master = requester/sync side.
//
// Handshake: a request transfers on a rising PIXCLK edge where MODE_VALID and
// MODE_READY are both 1; while MODE_READY is 0 the requester holds MODE_REQ/MODE_VALID.
interface video_mode_ctrl_if;
  logic [1:0] MODE_REQ;
  logic       MODE_VALID;
  logic       MODE_READY;
  logic [9:0] XPOS;
  logic [9:0] YPOS;
  logic [9:0] HV;
  logic [7:0] HFP;
  logic [7:0] HSP;
  logic [7:0] HBP;
  logic [9:0] VV;
  logic [7:0] VFP;
  logic [7:0] VSP;
  logic [7:0] VBP;
  logic [1:0] CUR_MODE;
  logic       BLANK;
  logic       BUSY;
  logic [1:0] dbg_state;

  modport slave (
    input  MODE_REQ, MODE_VALID, XPOS, YPOS,
    output MODE_READY, HV, HFP, HSP, HBP, VV, VFP, VSP, VBP,
           CUR_MODE, BLANK, BUSY, dbg_state
  );

  modport master (
    output MODE_REQ, MODE_VALID, XPOS, YPOS,
    input  MODE_READY, HV, HFP, HSP, HBP, VV, VFP, VSP, VBP,
           CUR_MODE, BLANK, BUSY, dbg_state
  );
endinterface

// File: rtl/video_mode_ctrl.sv
// Video timing mode controller: switches the sync generator's timing set only at
// frame start, then holds BLANK for MUTE_FRAMES further frames.
module video_mode_ctrl #(
  parameter logic [1:0]  DEFAULT_MODE = 2'd0,
  parameter int unsigned MUTE_FRAMES  = 2
) (
  input  logic             PIXCLK,
  input  logic             RESET,
  video_mode_ctrl_if.slave bus
);

  typedef struct packed {
    logic [9:0] hv;
    logic [7:0] hfp;
    logic [7:0] hsp;
    logic [7:0] hbp;
    logic [9:0] vv;
    logic [7:0] vfp;
    logic [7:0] vsp;
    logic [7:0] vbp;
  } timing_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PENDING = 2'd1,
    MUTE    = 2'd2
  } state_t;

  localparam logic [4:0] MUTE_N = 5'(MUTE_FRAMES);

  function automatic timing_t mode_table(input logic [1:0] m);
    timing_t t;
    case (m)
      2'd0:    t = '{10'd640, 8'd16, 8'd96,  8'd48, 10'd480, 8'd10, 8'd2, 8'd33};
      2'd1:    t = '{10'd640, 8'd16, 8'd96,  8'd48, 10'd400, 8'd12, 8'd2, 8'd35};
      2'd2:    t = '{10'd720, 8'd18, 8'd108, 8'd54, 10'd400, 8'd12, 8'd2, 8'd35};
      default: t = '{10'd512, 8'd8,  8'd16,  8'd8,  10'd384, 8'd2,  8'd2, 8'd2};
    endcase
    return t;
  endfunction

  state_t     state_q, state_d;
  logic [1:0] next_q, next_d;
  logic [1:0] cur_q, cur_d;
  timing_t    tim_q, tim_d;
  logic       blank_q, blank_d;
  logic [3:0] cnt_q, cnt_d;
  logic       fs;

  assign fs = (bus.XPOS == 10'd0) && (bus.YPOS == 10'd0);

  always_ff @(posedge PIXCLK or posedge RESET) begin
    if (RESET) begin
      state_q <= IDLE;
      next_q  <= DEFAULT_MODE;
      cur_q   <= DEFAULT_MODE;
      tim_q   <= mode_table(DEFAULT_MODE);
      blank_q <= 1'b0;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      next_q  <= next_d;
      cur_q   <= cur_d;
      tim_q   <= tim_d;
      blank_q <= blank_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    next_d  = next_q;
    cur_d   = cur_q;
    tim_d   = tim_q;
    blank_d = blank_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        // A request for the mode already on the outputs is consumed silently.
        if (bus.MODE_VALID && (bus.MODE_REQ != cur_q)) begin
          next_d  = bus.MODE_REQ;
          state_d = PENDING;
        end
      end
      PENDING: begin
        if (fs) begin
          tim_d = mode_table(next_q);
          cur_d = next_q;
          if (MUTE_N != 5'd0) begin
            blank_d = 1'b1;
            cnt_d   = 4'd0;
            state_d = MUTE;
          end else begin
            state_d = IDLE;
          end
        end
      end
      MUTE: begin
        if (fs) begin
          if (({1'b0, cnt_q} + 5'd1) == MUTE_N) begin
            blank_d = 1'b0;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.MODE_READY = (state_q == IDLE);
  assign bus.BUSY       = (state_q != IDLE);
  assign bus.BLANK      = blank_q;
  assign bus.CUR_MODE   = cur_q;
  assign bus.HV         = tim_q.hv;
  assign bus.HFP        = tim_q.hfp;
  assign bus.HSP        = tim_q.hsp;
  assign bus.HBP        = tim_q.hbp;
  assign bus.VV         = tim_q.vv;
  assign bus.VFP        = tim_q.vfp;
  assign bus.VSP        = tim_q.vsp;
  assign bus.VBP        = tim_q.vbp;
  assign bus.dbg_state  = state_q;

endmodule

// File: tb/tb_video_mode_ctrl.sv
// Directed bench for video_mode_ctrl: frame starts are emulated by briefly
// driving XPOS/YPOS to (0,0) instead of running full-length frames.
module tb_video_mode_ctrl;

  logic PIXCLK;
  logic RESET;
  int   n_cmp;
  int   n_err;

  video_mode_ctrl_if bus ();

  video_mode_ctrl #(
    .DEFAULT_MODE (2'd0),
    .MUTE_FRAMES  (2)
  ) dut (
    .PIXCLK (PIXCLK),
    .RESET  (RESET),
    .bus    (bus.slave)
  );

  // clock / reset
  initial PIXCLK = 1'b0;
  always #5 PIXCLK = ~PIXCLK;

  // expected timing table, horizontal then vertical
  int exp_tab [4][8] = '{
    '{640, 16, 96,  48, 480, 10, 2, 33},
    '{640, 16, 96,  48, 400, 12, 2, 35},
    '{720, 18, 108, 54, 400, 12, 2, 35},
    '{512, 8,  16,  8,  384, 2,  2, 2}
  };

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_timing(input string tag, input int m);
    chk({tag, ".HV"},  32'(bus.HV),  32'(exp_tab[m][0]));
    chk({tag, ".HFP"}, 32'(bus.HFP), 32'(exp_tab[m][1]));
    chk({tag, ".HSP"}, 32'(bus.HSP), 32'(exp_tab[m][2]));
    chk({tag, ".HBP"}, 32'(bus.HBP), 32'(exp_tab[m][3]));
    chk({tag, ".VV"},  32'(bus.VV),  32'(exp_tab[m][4]));
    chk({tag, ".VFP"}, 32'(bus.VFP), 32'(exp_tab[m][5]));
    chk({tag, ".VSP"}, 32'(bus.VSP), 32'(exp_tab[m][6]));
    chk({tag, ".VBP"}, 32'(bus.VBP), 32'(exp_tab[m][7]));
    chk({tag, ".CUR_MODE"}, 32'(bus.CUR_MODE), 32'(m));
  endtask

  task automatic chk_status(input string tag, input logic rdy, input logic busy, input logic blank);
    chk({tag, ".MODE_READY"}, 32'(bus.MODE_READY), 32'(rdy));
    chk({tag, ".BUSY"},       32'(bus.BUSY),       32'(busy));
    chk({tag, ".BLANK"},      32'(bus.BLANK),      32'(blank));
  endtask

  // driver tasks
  task automatic tick();
    @(posedge PIXCLK);
    #1;
  endtask

  task automatic mid_frame();
    bus.XPOS = 10'd100;
    bus.YPOS = 10'd50;
  endtask

  task automatic frame_start();
    bus.XPOS = 10'd0;
    bus.YPOS = 10'd0;
    tick();
    mid_frame();
  endtask

  task automatic request(input logic [1:0] m);
    bus.MODE_REQ   = m;
    bus.MODE_VALID = 1'b1;
    tick();
    bus.MODE_VALID = 1'b0;
  endtask

  initial begin
    n_cmp          = 0;
    n_err          = 0;
    bus.MODE_REQ   = 2'd0;
    bus.MODE_VALID = 1'b0;
    bus.XPOS       = 10'h3FF;
    bus.YPOS       = 10'h3FF;
    RESET          = 1'b1;

    // reset state, checked before any clock edge
    #2;
    chk_timing("rst", 0);
    chk_status("rst", 1'b1, 1'b0, 1'b0);
    chk("rst.state", 32'(bus.dbg_state), 32'd0);
    tick();
    tick();
    RESET = 1'b0;
    tick();
    chk_timing("blanked_pos", 0);

    // request mode 3 mid-frame
    mid_frame();
    request(2'd3);
    chk_status("req3.accept", 1'b0, 1'b1, 1'b0);
    chk("req3.state", 32'(bus.dbg_state), 32'd1);
    chk_timing("req3.hold", 0);
    tick();
    tick();
    chk_timing("req3.hold2", 0);
    frame_start();
    chk_timing("req3.switch", 3);
    chk_status("req3.switch", 1'b0, 1'b1, 1'b1);
    chk("req3.mute_state", 32'(bus.dbg_state), 32'd2);

    // muting: two further frame starts
    tick();
    tick();
    frame_start();
    chk_status("mute.fs1", 1'b0, 1'b1, 1'b1);
    tick();
    tick();
    tick();
    frame_start();
    chk_status("mute.fs2", 1'b1, 1'b0, 1'b0);
    chk_timing("mute.done", 3);

    // request for current mode: consumed with no effect
    request(2'd3);
    chk_status("same.accept", 1'b1, 1'b0, 1'b0);
    chk_timing("same.accept", 3);
    frame_start();
    chk_status("same.fs", 1'b1, 1'b0, 1'b0);
    chk_timing("same.fs", 3);

    // request mode 2 with FS in the acceptance cycle: that FS must not switch
    bus.XPOS = 10'd0;
    bus.YPOS = 10'd0;
    request(2'd2);
    mid_frame();
    chk_timing("req2.accept_fs", 3);
    chk_status("req2.accept_fs", 1'b0, 1'b1, 1'b0);
    request(2'd1);
    chk_timing("req2.ignore1", 3);
    tick();
    frame_start();
    chk_timing("req2.switch", 2);
    chk_status("req2.switch", 1'b0, 1'b1, 1'b1);

    // asynchronous reset in the middle of mute
    #3;
    RESET = 1'b1;
    #1;
    chk_timing("rst_mute", 0);
    chk_status("rst_mute", 1'b1, 1'b0, 1'b0);
    chk("rst_mute.state", 32'(bus.dbg_state), 32'd0);
    tick();
    RESET = 1'b0;
    tick();

    // mode 1 switch from the default mode, full mute sequence
    request(2'd1);
    frame_start();
    chk_timing("req1.switch", 1);
    chk_status("req1.switch", 1'b0, 1'b1, 1'b1);
    frame_start();
    chk_status("req1.fs1", 1'b0, 1'b1, 1'b1);
    frame_start();
    chk_status("req1.fs2", 1'b1, 1'b0, 1'b0);
    chk_timing("req1.done", 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
